// File: rtl/rename_resolver_pkg.sv
// Shared definitions for the rename/resolve stage: default widths, the "no register"
// physical index and the per-lane record held in the output register.
package pkg_defines;

    localparam int LANES_DEF     = 2;
    localparam int ARCH_W_DEF    = 5;
    localparam int PHYS_W_DEF    = 6;
    localparam int PAYLOAD_W_DEF = 64;

    localparam logic [PHYS_W_DEF-1:0] PHYS_NONE = '0;

    // Field widths follow the defaults above; non-default widths need this record resized too.
    typedef struct packed {
        logic [ARCH_W_DEF-1:0]    rd;
        logic [PHYS_W_DEF-1:0]    rs_1;
        logic [PHYS_W_DEF-1:0]    rs_2;
        logic [PHYS_W_DEF-1:0]    rn;
        logic                     tag;
        logic [PAYLOAD_W_DEF-1:0] payload;
    } rename_lane_t;

endpackage

// File: rtl/rename_resolver_lane_forward.sv
// Physical mapping of one source operand of lane LANE: the youngest older lane in the
// group writing that architectural register wins, otherwise the rename-table lookup.
module lane_forward
    import pkg_defines::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int ARCH_W = ARCH_W_DEF,
    parameter int PHYS_W = PHYS_W_DEF,
    parameter int LANE   = 0
) (
    input  logic [ARCH_W-1:0] i_src,
    input  logic [PHYS_W-1:0] i_q_src,
    input  logic [LANES-1:0]  i_need,
    input  logic [ARCH_W-1:0] i_rd   [LANES],
    input  logic [PHYS_W-1:0] i_q_rn [LANES],
    output logic [PHYS_W-1:0] o_phys
);

    always_comb begin
        o_phys = i_q_src;
        // Ascending scan: a later (younger) matching lane overrides an earlier one.
        for (int j = 0; j < LANES; j++) begin
            if (j < LANE && i_need[j] && i_rd[j] == i_src) begin
                o_phys = i_q_rn[j];
            end
        end
        if (i_src == '0) begin
            o_phys = PHYS_NONE;
        end
    end

endmodule

// File: rtl/rename_resolver.sv
// Rename/resolve stage: accepts a whole decoded group, substitutes physical registers,
// tags speculative lanes and registers the group toward the issuer.
module rename_resolver
    import pkg_defines::*;
#(
    parameter int LANES     = LANES_DEF,
    parameter int ARCH_W    = ARCH_W_DEF,
    parameter int PHYS_W    = PHYS_W_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [LANES-1:0]     i_lane_valid,
    input  logic [ARCH_W-1:0]    i_rd      [LANES],
    input  logic [ARCH_W-1:0]    i_rs_1    [LANES],
    input  logic [ARCH_W-1:0]    i_rs_2    [LANES],
    input  logic [LANES-1:0]     i_writes,
    input  logic [LANES-1:0]     i_jumps,
    input  logic [PAYLOAD_W-1:0] i_payload [LANES],
    input  logic [PHYS_W-1:0]    i_q_rs_1  [LANES],
    input  logic [PHYS_W-1:0]    i_q_rs_2  [LANES],
    input  logic [PHYS_W-1:0]    i_q_rn    [LANES],
    output logic [LANES-1:0]     o_alloc,
    input  logic                 i_halt,
    input  logic                 i_br_resolve,
    input  logic                 i_br_mispredict,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [LANES-1:0]     o_lane_valid,
    output logic [LANES-1:0]     o_tag,
    output logic [PHYS_W-1:0]    o_rs_1    [LANES],
    output logic [PHYS_W-1:0]    o_rs_2    [LANES],
    output logic [PHYS_W-1:0]    o_rn      [LANES],
    output logic [ARCH_W-1:0]    o_rd      [LANES],
    output logic [PAYLOAD_W-1:0] o_payload [LANES],
    output logic                 o_panic
);

    logic [LANES-1:0]  need;
    logic [LANES-1:0]  jump;
    logic [LANES-1:0]  older_jump;
    logic [LANES-1:0]  starve;
    logic [PHYS_W-1:0] fwd_rs_1 [LANES];
    logic [PHYS_W-1:0] fwd_rs_2 [LANES];
    logic              tag_eff;
    logic              multi_jump;
    logic              accept;

    logic              o_valid_q, o_valid_d;
    logic [LANES-1:0]  lane_valid_q, lane_valid_d;
    logic              tag_active_q, tag_active_d;
    logic              panic_q, panic_d;
    rename_lane_t      out_q [LANES];
    rename_lane_t      out_d [LANES];

    always_comb begin
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            need[k]       = i_lane_valid[k] & i_writes[k] & (i_rd[k] != '0);
            jump[k]       = i_lane_valid[k] & i_jumps[k];
            starve[k]     = need[k] & (i_q_rn[k] == PHYS_NONE);
            older_jump[k] = seen;
            seen          = seen | jump[k];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_fwd
        lane_forward #(.LANES(LANES), .ARCH_W(ARCH_W), .PHYS_W(PHYS_W), .LANE(k)) u_fwd_rs_1 (
            .i_src   (i_rs_1[k]),
            .i_q_src (i_q_rs_1[k]),
            .i_need  (need),
            .i_rd    (i_rd),
            .i_q_rn  (i_q_rn),
            .o_phys  (fwd_rs_1[k])
        );
        lane_forward #(.LANES(LANES), .ARCH_W(ARCH_W), .PHYS_W(PHYS_W), .LANE(k)) u_fwd_rs_2 (
            .i_src   (i_rs_2[k]),
            .i_q_src (i_q_rs_2[k]),
            .i_need  (need),
            .i_rd    (i_rd),
            .i_q_rn  (i_q_rn),
            .o_phys  (fwd_rs_2[k])
        );
    end

    // A resolve this cycle ends speculation before the incoming group is tagged.
    assign tag_eff    = tag_active_q & ~i_br_resolve;
    assign multi_jump = |(jump & older_jump);

    assign accept = reset & i_valid & ~i_halt & ~i_br_mispredict
                  & (~o_valid_q | i_ready)
                  & ~(|starve) & ~multi_jump
                  & ~((|jump) & tag_eff);

    assign o_ready = accept;
    assign o_alloc = accept ? need : '0;

    always_comb begin
        // NOTE: every target gets its hold value first, so no path through the branches below can infer a latch.
        out_d        = out_q;
        lane_valid_d = lane_valid_q;
        o_valid_d    = o_valid_q;
        tag_active_d = tag_eff | (accept & (|jump));
        panic_d      = panic_q | (i_br_resolve & ~tag_active_q) | (i_br_mispredict & ~i_br_resolve);

        if (accept) begin
            o_valid_d    = 1'b1;
            lane_valid_d = i_lane_valid;
            for (int k = 0; k < LANES; k++) begin
                out_d[k].rd      = i_rd[k];
                out_d[k].rs_1    = fwd_rs_1[k];
                out_d[k].rs_2    = fwd_rs_2[k];
                out_d[k].rn      = need[k] ? i_q_rn[k] : PHYS_NONE;
                out_d[k].tag     = i_lane_valid[k] & ~jump[k] & (tag_eff | older_jump[k]);
                out_d[k].payload = i_payload[k];
            end
        end else begin
            if (o_valid_q && i_ready) begin
                o_valid_d = 1'b0;
            end
            // Mispredict squashes speculative lanes even while the issuer is stalling us.
            if (i_br_mispredict) begin
                for (int k = 0; k < LANES; k++) begin
                    if (out_q[k].tag) begin
                        lane_valid_d[k] = 1'b0;
                        out_d[k].tag    = 1'b0;
                    end
                end
                if (lane_valid_d == '0) begin
                    o_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_valid_q    <= 1'b0;
            lane_valid_q <= '0;
            tag_active_q <= 1'b0;
            panic_q      <= 1'b0;
            // NOTE: the data register is reset too, so every output reads 0 while reset is held.
            for (int k = 0; k < LANES; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            o_valid_q    <= o_valid_d;
            lane_valid_q <= lane_valid_d;
            tag_active_q <= tag_active_d;
            panic_q      <= panic_d;
            out_q        <= out_d;
        end
    end

    assign o_valid      = o_valid_q;
    assign o_lane_valid = lane_valid_q;
    assign o_panic      = panic_q;

    always_comb begin
        o_tag = '0;
        for (int k = 0; k < LANES; k++) begin
            o_tag[k]     = out_q[k].tag;
            o_rd[k]      = out_q[k].rd;
            o_rs_1[k]    = out_q[k].rs_1;
            o_rs_2[k]    = out_q[k].rs_2;
            o_rn[k]      = out_q[k].rn;
            o_payload[k] = out_q[k].payload;
        end
    end

endmodule

// File: tb/tb_rename_resolver.sv
// Self-checking bench for rename_resolver: directed scenarios plus randomized groups
// compared against a behavioural model of the group rename/accept/speculation rules.
module tb_rename_resolver;

    localparam int L  = 2;
    localparam int L4 = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Two-lane DUT
    logic          i_valid, i_halt, i_br_resolve, i_br_mispredict, i_ready;
    logic [L-1:0]  i_lane_valid, i_writes, i_jumps;
    logic [4:0]    i_rd [L], i_rs_1 [L], i_rs_2 [L];
    logic [5:0]    i_q_rs_1 [L], i_q_rs_2 [L], i_q_rn [L];
    logic [63:0]   i_payload [L];
    logic          o_ready, o_valid, o_panic;
    logic [L-1:0]  o_alloc, o_lane_valid, o_tag;
    logic [5:0]    o_rs_1 [L], o_rs_2 [L], o_rn [L];
    logic [4:0]    o_rd [L];
    logic [63:0]   o_payload [L];

    // Four-lane DUT
    logic          f_valid;
    logic [L4-1:0] f_lane_valid, f_writes, f_jumps;
    logic [4:0]    f_rd [L4], f_rs_1 [L4], f_rs_2 [L4];
    logic [5:0]    f_q_rs_1 [L4], f_q_rs_2 [L4], f_q_rn [L4];
    logic [63:0]   f_payload [L4];
    logic          f_o_ready, f_o_valid, f_o_panic;
    logic [L4-1:0] f_o_alloc, f_o_lane_valid, f_o_tag;
    logic [5:0]    f_o_rs_1 [L4], f_o_rs_2 [L4], f_o_rn [L4];
    logic [4:0]    f_o_rd [L4];
    logic [63:0]   f_o_payload [L4];

    rename_resolver #(.LANES(L)) dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_lane_valid(i_lane_valid), .i_rd(i_rd), .i_rs_1(i_rs_1), .i_rs_2(i_rs_2),
        .i_writes(i_writes), .i_jumps(i_jumps), .i_payload(i_payload),
        .i_q_rs_1(i_q_rs_1), .i_q_rs_2(i_q_rs_2), .i_q_rn(i_q_rn), .o_alloc(o_alloc),
        .i_halt(i_halt), .i_br_resolve(i_br_resolve), .i_br_mispredict(i_br_mispredict),
        .o_valid(o_valid), .i_ready(i_ready), .o_lane_valid(o_lane_valid), .o_tag(o_tag),
        .o_rs_1(o_rs_1), .o_rs_2(o_rs_2), .o_rn(o_rn), .o_rd(o_rd),
        .o_payload(o_payload), .o_panic(o_panic)
    );

    rename_resolver #(.LANES(L4)) dut4 (
        .clock(clock), .reset(reset), .i_valid(f_valid), .o_ready(f_o_ready),
        .i_lane_valid(f_lane_valid), .i_rd(f_rd), .i_rs_1(f_rs_1), .i_rs_2(f_rs_2),
        .i_writes(f_writes), .i_jumps(f_jumps), .i_payload(f_payload),
        .i_q_rs_1(f_q_rs_1), .i_q_rs_2(f_q_rs_2), .i_q_rn(f_q_rn), .o_alloc(f_o_alloc),
        .i_halt(1'b0), .i_br_resolve(1'b0), .i_br_mispredict(1'b0),
        .o_valid(f_o_valid), .i_ready(1'b1), .o_lane_valid(f_o_lane_valid), .o_tag(f_o_tag),
        .o_rs_1(f_o_rs_1), .o_rs_2(f_o_rs_2), .o_rn(f_o_rn), .o_rd(f_o_rd),
        .o_payload(f_o_payload), .o_panic(f_o_panic)
    );

    // Reference model state: what the issuer should currently see.
    logic          m_valid, m_tag_active, m_panic;
    logic [L-1:0]  m_lv, m_tag;
    logic [5:0]    m_rs1 [L], m_rs2 [L], m_rn [L];
    logic [4:0]    m_rd [L];
    logic [63:0]   m_pl [L];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic needs(int k);
        return i_lane_valid[k] && i_writes[k] && (i_rd[k] != 5'd0);
    endfunction

    // Search older lanes youngest-first for a producer of s.
    function automatic logic [5:0] src_map(int k, logic [4:0] s, logic [5:0] q);
        if (s == 5'd0) return 6'd0;
        for (int j = k - 1; j >= 0; j--) begin
            if (needs(j) && i_rd[j] == s) return i_q_rn[j];
        end
        return q;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_tag_active = 0; m_panic = 0; m_lv = '0; m_tag = '0;
    endtask

    task automatic clear_inputs();
        i_valid = 0; i_halt = 0; i_br_resolve = 0; i_br_mispredict = 0; i_ready = 1;
        i_lane_valid = '0; i_writes = '0; i_jumps = '0;
        for (int k = 0; k < L; k++) begin
            i_rd[k] = 0; i_rs_1[k] = 0; i_rs_2[k] = 0;
            i_q_rs_1[k] = 0; i_q_rs_2[k] = 0; i_q_rn[k] = 0; i_payload[k] = 0;
        end
    endtask

    task automatic set_lane(input int k, input logic v, input logic w, input logic j,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [5:0] qrs1, input logic [5:0] qrs2, input logic [5:0] qrn);
        i_lane_valid[k] = v; i_writes[k] = w; i_jumps[k] = j;
        i_rd[k] = rd; i_rs_1[k] = rs1; i_rs_2[k] = rs2;
        i_q_rs_1[k] = qrs1; i_q_rs_2[k] = qrs2; i_q_rn[k] = qrn;
        i_payload[k] = {32'hC0DE_0000 | 32'(k), $urandom};
    endtask

    task automatic check_outputs();
        check("o_valid", o_valid, m_valid);
        check("o_panic", o_panic, m_panic);
        check("tag_active", dut.tag_active_q, m_tag_active);
        if (m_valid) begin
            check("o_lane_valid", o_lane_valid, m_lv);
            check("o_tag", o_tag, m_tag);
            for (int k = 0; k < L; k++) begin
                if (m_lv[k]) begin
                    check($sformatf("o_rd[%0d]", k), o_rd[k], m_rd[k]);
                    check($sformatf("o_rs_1[%0d]", k), o_rs_1[k], m_rs1[k]);
                    check($sformatf("o_rs_2[%0d]", k), o_rs_2[k], m_rs2[k]);
                    check($sformatf("o_rn[%0d]", k), o_rn[k], m_rn[k]);
                    check($sformatf("o_payload[%0d]", k), o_payload[k], m_pl[k]);
                end
            end
        end
    endtask

    // Called just after a falling edge with the inputs already driven.
    task automatic step();
        logic         acc;
        logic [L-1:0] alloc;
        int           jumps;
        logic         early_tag;
        logic         older;
        early_tag = m_tag_active && !i_br_resolve;
        acc   = i_valid && !i_halt && !i_br_mispredict && (!m_valid || i_ready);
        alloc = '0;
        jumps = 0;
        for (int k = 0; k < L; k++) begin
            if (i_lane_valid[k] && i_jumps[k]) jumps++;
            if (needs(k)) begin
                alloc[k] = 1'b1;
                if (i_q_rn[k] == 6'd0) acc = 0;
            end
        end
        if (jumps > 1 || (jumps == 1 && early_tag)) acc = 0;
        if (!acc) alloc = '0;
        #1;
        check("o_ready", o_ready, acc);
        check("o_alloc", o_alloc, alloc);
        @(posedge clock);
        #1;
        m_panic = m_panic || (i_br_resolve && !m_tag_active) || (i_br_mispredict && !i_br_resolve);
        if (acc) begin
            m_valid = 1;
            older   = 0;
            for (int k = 0; k < L; k++) begin
                m_lv[k]  = i_lane_valid[k];
                m_rd[k]  = i_rd[k];
                m_rs1[k] = src_map(k, i_rs_1[k], i_q_rs_1[k]);
                m_rs2[k] = src_map(k, i_rs_2[k], i_q_rs_2[k]);
                m_rn[k]  = needs(k) ? i_q_rn[k] : 6'd0;
                m_pl[k]  = i_payload[k];
                if (!i_lane_valid[k] || i_jumps[k]) m_tag[k] = 0;
                else m_tag[k] = early_tag || older;
                if (i_lane_valid[k] && i_jumps[k]) older = 1;
            end
        end else begin
            if (m_valid && i_ready) m_valid = 0;
            if (i_br_mispredict) begin
                m_lv  = m_lv & ~m_tag;
                m_tag = '0;
                if (m_lv == '0) m_valid = 0;
            end
        end
        if (i_br_resolve) m_tag_active = 0;
        if (acc && jumps > 0) m_tag_active = 1;
        check_outputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        f_valid = 0; f_lane_valid = '0; f_writes = '0; f_jumps = '0;
        for (int k = 0; k < L4; k++) begin
            f_rd[k] = 0; f_rs_1[k] = 0; f_rs_2[k] = 0;
            f_q_rs_1[k] = 0; f_q_rs_2[k] = 0; f_q_rn[k] = 0; f_payload[k] = 0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset: outputs cleared and no accept even with a valid group offered.
        i_valid = 1;
        set_lane(0, 1, 1, 0, 3, 1, 2, 4, 5, 12);
        #2;
        check("rst_o_ready", o_ready, 0);
        check("rst_o_alloc", o_alloc, 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_panic", o_panic, 0);
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        step();

        // Intra-group forwarding of rd=3 from lane0 into lane1 rs_1.
        @(negedge clock);
        clear_inputs(); i_valid = 1;
        set_lane(0, 1, 1, 0, 3, 1, 2, 5, 6, 12);
        set_lane(1, 1, 0, 0, 7, 3, 0, 7, 9, 40);
        step();
        check("fwd_rs_1", o_rs_1[1], 12);
        check("fwd_rs_2", o_rs_2[1], 0);
        check("fwd_valid", o_valid, 1);

        // Lane1 starved of a free register until one is offered.
        @(negedge clock);
        clear_inputs(); i_valid = 1;
        set_lane(0, 1, 0, 0, 0, 1, 1, 1, 1, 0);
        set_lane(1, 1, 1, 0, 4, 2, 2, 3, 3, 0);
        step();
        @(negedge clock);
        step();
        @(negedge clock);
        i_q_rn[1] = 9;
        step();
        check("starve_rn", o_rn[1], 9);

        // Jump in lane0 tags lane1; second jump waits for resolve.
        @(negedge clock);
        clear_inputs(); i_valid = 1;
        set_lane(0, 1, 0, 1, 0, 1, 2, 3, 4, 1);
        set_lane(1, 1, 1, 0, 5, 6, 7, 8, 9, 14);
        step();
        check("jump_tag", o_tag, 2'b10);
        @(negedge clock);
        set_lane(0, 1, 0, 1, 0, 2, 3, 4, 5, 1);
        set_lane(1, 1, 1, 0, 6, 5, 0, 10, 0, 15);
        step();
        @(negedge clock);
        step();
        check("jump_stall_ready", o_ready, 0);
        @(negedge clock);
        i_br_resolve = 1;
        step();
        check("jump_again_tag", o_tag, 2'b10);

        // Fully tagged group held by the issuer, then mispredicted.
        @(negedge clock);
        clear_inputs(); i_valid = 1;
        set_lane(0, 1, 1, 0, 8, 1, 1, 2, 2, 20);
        set_lane(1, 1, 1, 0, 9, 8, 0, 3, 3, 21);
        step();
        check("spec_tag", o_tag, 2'b11);
        @(negedge clock);
        clear_inputs(); i_ready = 0;
        step();
        @(negedge clock);
        i_br_resolve = 1; i_br_mispredict = 1;
        step();
        check("mispredict_valid", o_valid, 0);
        check("mispredict_tag_active", dut.tag_active_q, 0);

        // Four lanes: two writers of rd=5, youngest older producer wins.
        @(negedge clock);
        clear_inputs();
        f_valid = 1; f_lane_valid = 4'b1111; f_writes = 4'b0111; f_jumps = '0;
        f_rd[0] = 5; f_rd[1] = 6; f_rd[2] = 5; f_rd[3] = 1;
        f_rs_1[1] = 5; f_rs_1[3] = 5; f_q_rs_1[1] = 3; f_q_rs_1[3] = 3;
        f_q_rn[0] = 20; f_q_rn[1] = 21; f_q_rn[2] = 22; f_q_rn[3] = 23;
        #1;
        check("l4_ready", f_o_ready, 1);
        check("l4_alloc", f_o_alloc, 4'b0111);
        @(posedge clock);
        #1;
        check("l4_rs_1[3]", f_o_rs_1[3], 22);
        check("l4_rs_1[1]", f_o_rs_1[1], 20);
        check("l4_rn[3]", f_o_rn[3], 0);
        f_valid = 0;

        // Randomized groups against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            i_valid         = ($urandom_range(0, 3) != 0);
            i_halt          = ($urandom_range(0, 15) == 0);
            i_ready         = ($urandom_range(0, 3) != 0);
            i_br_resolve    = m_tag_active && ($urandom_range(0, 2) == 0);
            i_br_mispredict = i_br_resolve && ($urandom_range(0, 1) == 0);
            for (int k = 0; k < L; k++) begin
                set_lane(k, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 7) == 0, 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         6'($urandom_range(1, 63)), 6'($urandom_range(1, 63)),
                         ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63)));
            end
            step();
        end

        // Retire any open speculation, then provoke a panic.
        @(negedge clock);
        clear_inputs();
        i_br_resolve = m_tag_active;
        step();
        @(negedge clock);
        clear_inputs(); i_br_resolve = 1;
        step();
        @(negedge clock);
        clear_inputs();
        step();
        check("panic_held", o_panic, 1);

        // Load a group, stall it, then reset asynchronously mid-cycle.
        @(negedge clock);
        clear_inputs(); i_valid = 1;
        set_lane(0, 1, 1, 0, 2, 3, 4, 5, 6, 30);
        set_lane(1, 1, 1, 0, 3, 2, 0, 7, 0, 31);
        step();
        @(negedge clock);
        i_ready = 0;
        step();
        @(negedge clock);
        i_ready = 1;
        #2;
        reset = 1'b0;
        #1;
        check("arst_o_valid", o_valid, 0);
        check("arst_o_lane_valid", o_lane_valid, 0);
        check("arst_o_tag", o_tag, 0);
        check("arst_o_panic", o_panic, 0);
        check("arst_o_ready", o_ready, 0);
        check("arst_o_alloc", o_alloc, 0);
        check("arst_o_rn[0]", o_rn[0], 0);
        check("arst_o_rs_1[1]", o_rs_1[1], 0);
        check("arst_o_rd[0]", o_rd[0], 0);
        check("arst_o_payload[0]", o_payload[0], 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        step();
        @(negedge clock);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
